// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI4-Lite write-channel controller.
package axi_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_W,
    ST_WAIT_A,
    ST_WRITE,
    ST_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned IDX_MSB = 5;
  localparam int unsigned IDX_LSB = 2;

endpackage

// File: rtl/axi_wr_ctrl.sv
// AXI4-Lite write controller: joins AW and W in either order, issues one
// register-file write per transaction and returns a B response.
module axi_wr_ctrl
  import axi_wr_pkg::*;
#(
  parameter int unsigned NREG = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iAWADDR,
  input  logic        iAWVALID,
  input  logic        iAWREADY,
  output logic        oBUSY,
  input  logic [31:0] iWDATA,
  input  logic [3:0]  iWSTRB,
  input  logic        iWVALID,
  output logic        oWREADY,
  output logic        oBVALID,
  output logic [1:0]  oBRESP,
  input  logic        iBREADY,
  output logic        oREG_WE,
  output logic [3:0]  oREG_IDX,
  output logic [31:0] oREG_WDATA,
  output logic [3:0]  oREG_WSTRB
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        aw_take;
  logic        addr_ok;
  logic [IDX_MSB-IDX_LSB:0] idx;
  logic        addr_unused;

  assign oWREADY = (state == ST_IDLE) || (state == ST_WAIT_W);
  assign aw_hs   = iAWVALID & iAWREADY;
  assign w_hs    = iWVALID & oWREADY;
  // Addresses are only taken while none is held, even if upstream ready misbehaves.
  assign aw_take = aw_hs && ((state == ST_IDLE) || (state == ST_WAIT_A));

  assign idx         = addr_q[IDX_MSB:IDX_LSB];
  assign addr_ok     = (addr_q[31:IDX_MSB+1] == '0) && (32'(idx) < NREG);
  assign addr_unused = ^addr_q[IDX_LSB-1:0];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      state <= state_nx;
      if (aw_take) addr_q <= iAWADDR;
      if (w_hs) begin
        data_q <= iWDATA;
        strb_q <= iWSTRB;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    oBUSY      = aw_hs;
    oBVALID    = 1'b0;
    oBRESP     = RESP_OKAY;
    oREG_WE    = 1'b0;
    oREG_IDX   = '0;
    oREG_WDATA = '0;
    oREG_WSTRB = '0;
    unique case (state)
      ST_IDLE: begin
        if (aw_hs && w_hs) state_nx = ST_WRITE;
        else if (aw_hs)    state_nx = ST_WAIT_W;
        else if (w_hs)     state_nx = ST_WAIT_A;
      end
      ST_WAIT_W: begin
        oBUSY = 1'b1;
        if (w_hs) state_nx = ST_WRITE;
      end
      ST_WAIT_A: begin
        oBUSY = 1'b1;
        if (aw_hs) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        oBUSY    = 1'b1;
        state_nx = ST_RESP;
        if (addr_ok) begin
          oREG_WE    = 1'b1;
          oREG_IDX   = idx;
          oREG_WDATA = data_q;
          oREG_WSTRB = strb_q;
        end
      end
      ST_RESP: begin
        oBVALID = 1'b1;
        oBRESP  = addr_ok ? RESP_OKAY : RESP_SLVERR;
        // Busy drops during the B handshake so upstream ready is back on IDLE entry.
        oBUSY   = aw_hs | ~iBREADY;
        if (iBREADY) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Bench for axi_wr_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model.
module tb_axi_wr_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iAWADDR;
  logic        iAWVALID;
  logic        iAWREADY;
  logic        oBUSY;
  logic [31:0] iWDATA;
  logic [3:0]  iWSTRB;
  logic        iWVALID;
  logic        oWREADY;
  logic        oBVALID;
  logic [1:0]  oBRESP;
  logic        iBREADY;
  logic        oREG_WE;
  logic [3:0]  oREG_IDX;
  logic [31:0] oREG_WDATA;
  logic [3:0]  oREG_WSTRB;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;
  int n_we = 0;

  axi_wr_ctrl #(.NREG(8)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iAWADDR(iAWADDR), .iAWVALID(iAWVALID), .iAWREADY(iAWREADY), .oBUSY(oBUSY),
    .iWDATA(iWDATA), .iWSTRB(iWSTRB), .iWVALID(iWVALID), .oWREADY(oWREADY),
    .oBVALID(oBVALID), .oBRESP(oBRESP), .iBREADY(iBREADY),
    .oREG_WE(oREG_WE), .oREG_IDX(oREG_IDX), .oREG_WDATA(oREG_WDATA), .oREG_WSTRB(oREG_WSTRB)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream address-channel machine: ready drops on accept, returns once busy clears.
  always @(posedge iCLK) begin
    if (iRST)                       iAWREADY <= 1'b1;
    else if (iAWVALID && iAWREADY)  iAWREADY <= 1'b0;
    else if (!iAWREADY && !oBUSY)   iAWREADY <= 1'b1;
  end

  // Transaction-level model: what is held, and which phase follows the join.
  bit        m_have_a, m_have_d, m_wr, m_resp;
  bit [31:0] m_addr, m_data;
  bit [3:0]  m_strb;

  always @(posedge iCLK) begin : model_upd
    bit aw_hs, w_hs;
    aw_hs = iAWVALID && iAWREADY;
    w_hs  = iWVALID && !m_have_d;
    if (iRST) begin
      m_have_a = 0; m_have_d = 0; m_wr = 0; m_resp = 0;
    end else if (m_resp) begin
      if (iBREADY) begin
        m_have_a = 0; m_have_d = 0; m_resp = 0;
      end
    end else if (m_wr) begin
      m_wr = 0; m_resp = 1;
    end else begin
      if (aw_hs && !m_have_a) begin m_have_a = 1; m_addr = iAWADDR; end
      if (w_hs) begin m_have_d = 1; m_data = iWDATA; m_strb = iWSTRB; end
      if (m_have_a && m_have_d) m_wr = 1;
    end
  end

  always @(negedge iCLK) begin : compare
    bit ok, e_we, e_busy;
    if (chk_en) begin
      ok     = (m_addr[31:6] == 0) && (m_addr[5:2] < 8);
      e_we   = m_wr && ok;
      e_busy = (iAWVALID && iAWREADY) || ((m_have_a || m_have_d) && !(m_resp && iBREADY));
      chk("m_we",     {31'd0, oREG_WE},  {31'd0, e_we});
      chk("m_idx",    {28'd0, oREG_IDX}, e_we ? {28'd0, m_addr[5:2]} : 32'd0);
      chk("m_wdata",  oREG_WDATA,        e_we ? m_data : 32'd0);
      chk("m_wstrb",  {28'd0, oREG_WSTRB}, e_we ? {28'd0, m_strb} : 32'd0);
      chk("m_wready", {31'd0, oWREADY},  {31'd0, !m_have_d});
      chk("m_bvalid", {31'd0, oBVALID},  {31'd0, m_resp});
      chk("m_bresp",  {30'd0, oBRESP},   (m_resp && !ok) ? 32'd2 : 32'd0);
      chk("m_busy",   {31'd0, oBUSY},    {31'd0, e_busy});
      if (oREG_WE === 1'b1) n_we++;
    end
  end

  task automatic cyc();
    @(posedge iCLK); #1;
  endtask

  // Same-cycle AW+W with iBREADY=1; expectations supplied as literals.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic e_we, input logic [3:0] e_idx, input logic [1:0] e_resp);
    cyc(); iAWVALID = 1; iAWADDR = a; iWVALID = 1; iWDATA = d; iWSTRB = s; iBREADY = 1;
    @(negedge iCLK); chk("t_busy_hs", {31'd0, oBUSY}, 32'd1);
    cyc(); iAWVALID = 0; iWVALID = 0;
    @(negedge iCLK);
    chk("t_we",    {31'd0, oREG_WE}, {31'd0, e_we});
    chk("t_idx",   {28'd0, oREG_IDX}, {28'd0, e_idx});
    chk("t_wdata", oREG_WDATA, e_we ? d : 32'd0);
    cyc(); @(negedge iCLK);
    chk("t_bvalid", {31'd0, oBVALID}, 32'd1);
    chk("t_bresp",  {30'd0, oBRESP}, {30'd0, e_resp});
    chk("t_busy_b", {31'd0, oBUSY}, 32'd0);
    cyc(); @(negedge iCLK);
    chk("t_idle_bvalid", {31'd0, oBVALID}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = $urandom;
    else a = {26'd0, 4'($urandom), 2'($urandom)};
    return a;
  endfunction

  initial begin
    iRST = 1; iAWADDR = 0; iAWVALID = 0; iWDATA = 0; iWSTRB = 0; iWVALID = 0; iBREADY = 1;
    @(posedge iCLK); @(posedge iCLK);
    @(negedge iCLK);
    chk_en = 1;
    chk("rst_bvalid", {31'd0, oBVALID}, 32'd0);
    chk("rst_bresp",  {30'd0, oBRESP}, 32'd0);
    chk("rst_we",     {31'd0, oREG_WE}, 32'd0);
    chk("rst_wready", {31'd0, oWREADY}, 32'd1);
    chk("rst_busy",   {31'd0, oBUSY}, 32'd0);
    cyc(); iRST = 0;

    // Same-cycle join
    cyc(); iAWVALID = 1; iAWADDR = 32'h8; iWVALID = 1; iWDATA = 32'hDEAD_BEEF; iWSTRB = 4'hF;
    @(negedge iCLK);
    chk("a_busy", {31'd0, oBUSY}, 32'd1);
    chk("a_wready", {31'd0, oWREADY}, 32'd1);
    cyc(); iAWVALID = 0; iWVALID = 0;
    @(negedge iCLK);
    chk("a_we", {31'd0, oREG_WE}, 32'd1);
    chk("a_idx", {28'd0, oREG_IDX}, 32'd2);
    chk("a_wdata", oREG_WDATA, 32'hDEAD_BEEF);
    chk("a_wstrb", {28'd0, oREG_WSTRB}, 32'hF);
    chk("a_bvalid_early", {31'd0, oBVALID}, 32'd0);
    cyc(); @(negedge iCLK);
    chk("a_bvalid", {31'd0, oBVALID}, 32'd1);
    chk("a_bresp", {30'd0, oBRESP}, 32'd0);
    chk("a_we_off", {31'd0, oREG_WE}, 32'd0);
    cyc(); @(negedge iCLK);
    chk("a_awready_back", {31'd0, iAWREADY}, 32'd1);

    // W before AW, three idle cycles in between
    cyc(); iWVALID = 1; iWDATA = 32'h1234_5678; iWSTRB = 4'h3;
    @(negedge iCLK); chk("b_busy0", {31'd0, oBUSY}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); iWVALID = 0;
      @(negedge iCLK);
      chk("b_wready_wait", {31'd0, oWREADY}, 32'd0);
      chk("b_busy_wait", {31'd0, oBUSY}, 32'd1);
    end
    cyc(); iAWVALID = 1; iAWADDR = 32'h4;
    @(negedge iCLK); chk("b_we_pre", {31'd0, oREG_WE}, 32'd0);
    cyc(); iAWVALID = 0;
    @(negedge iCLK);
    chk("b_we", {31'd0, oREG_WE}, 32'd1);
    chk("b_idx", {28'd0, oREG_IDX}, 32'd1);
    chk("b_wdata", oREG_WDATA, 32'h1234_5678);
    chk("b_wstrb", {28'd0, oREG_WSTRB}, 32'h3);
    cyc(); @(negedge iCLK); chk("b_bresp", {30'd0, oBRESP}, 32'd0);
    cyc();

    // Decode boundaries
    txn(32'h0000_0020, 32'h1111_1111, 4'hF, 1'b0, 4'd0, 2'b10);
    txn(32'h0000_0040, 32'h2222_2222, 4'hF, 1'b0, 4'd0, 2'b10);
    txn(32'h8000_0008, 32'h3333_3333, 4'hF, 1'b0, 4'd0, 2'b10);
    txn(32'h0000_001C, 32'h4444_4444, 4'h0, 1'b1, 4'd7, 2'b00);
    txn(32'h0000_0003, 32'h5555_5555, 4'h5, 1'b1, 4'd0, 2'b00);

    // B back-pressure for five cycles
    cyc(); iBREADY = 0; iAWVALID = 1; iAWADDR = 32'hC; iWVALID = 1; iWDATA = 32'h0BAD_F00D; iWSTRB = 4'hA;
    cyc(); iAWVALID = 0; iWVALID = 0;
    @(negedge iCLK); chk("c_idx", {28'd0, oREG_IDX}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      cyc(); @(negedge iCLK);
      chk("c_bvalid", {31'd0, oBVALID}, 32'd1);
      chk("c_bresp", {30'd0, oBRESP}, 32'd0);
      chk("c_busy", {31'd0, oBUSY}, 32'd1);
      chk("c_awready_low", {31'd0, iAWREADY}, 32'd0);
    end
    cyc(); iBREADY = 1;
    @(negedge iCLK); chk("c_busy_bhs", {31'd0, oBUSY}, 32'd0);
    cyc(); @(negedge iCLK);
    chk("c_awready_back", {31'd0, iAWREADY}, 32'd1);
    chk("c_bvalid_off", {31'd0, oBVALID}, 32'd0);

    // AW held valid continuously with changing addresses
    cyc(); iAWVALID = 1; iAWADDR = 32'h4;
    cyc(); iAWADDR = 32'h8;
    cyc(); iAWADDR = 32'hC; iWVALID = 1; iWDATA = 32'hA5A5_A5A5; iWSTRB = 4'hF;
    cyc(); iAWADDR = 32'h10; iWVALID = 0;
    @(negedge iCLK);
    chk("d_we", {31'd0, oREG_WE}, 32'd1);
    chk("d_idx_first", {28'd0, oREG_IDX}, 32'd1);
    cyc(); iAWADDR = 32'h14;
    cyc(); iAWADDR = 32'h18;
    @(negedge iCLK); chk("d_busy_next_aw", {31'd0, oBUSY}, 32'd1);
    cyc(); iAWVALID = 0; iWVALID = 1; iWDATA = 32'h0000_0001;
    cyc(); iWVALID = 0;
    @(negedge iCLK); chk("d_idx_second", {28'd0, oREG_IDX}, 32'd6);
    cyc(); cyc();

    // Reset while the address is held
    cyc(); iAWVALID = 1; iAWADDR = 32'h8;
    cyc(); iAWVALID = 0;
    @(negedge iCLK); chk("e_busy_ww", {31'd0, oBUSY}, 32'd1);
    cyc(); iRST = 1;
    cyc(); iRST = 0;
    @(negedge iCLK);
    chk("e_wready", {31'd0, oWREADY}, 32'd1);
    chk("e_busy", {31'd0, oBUSY}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge iCLK);
      chk("e_no_we", {31'd0, oREG_WE}, 32'd0);
      chk("e_no_bvalid", {31'd0, oBVALID}, 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      iRST     = ($urandom_range(0, 299) == 0);
      iAWVALID = $urandom_range(0, 1) == 1;
      iAWADDR  = rand_addr();
      iWVALID  = $urandom_range(0, 2) == 0;
      iWDATA   = $urandom;
      iWSTRB   = 4'($urandom);
      iBREADY  = $urandom_range(0, 2) != 0;
    end
    cyc(); iRST = 0; iAWVALID = 0; iWVALID = 0; iBREADY = 1;
    repeat (4) cyc();
    @(negedge iCLK);
    chk("rand_writes_seen", {31'd0, n_we > 100}, 32'd1);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_wr_ctrl.md
AXI_WR_CTRL -- requirements
Module: axi_wr_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 8, giving the number of 32-bit registers decoded (2..16).
REQ-002 SHALL have port iCLK  input  1  sole clock, all logic on its rising edge.
REQ-003 SHALL have port iRST  input  1  synchronous active-high reset.
REQ-004 SHALL have port iAWADDR  input  32  write address from the AXI4-Lite master.
REQ-005 SHALL have port iAWVALID  input  1  write address valid.
REQ-006 SHALL have port iAWREADY  input  1  write address ready, driven by the upstream address-channel state machine.
REQ-007 SHALL have port oBUSY  output  1  busy flag that throttles the address-channel ready.
REQ-008 SHALL have ports iWDATA input 32, iWSTRB input 4, iWVALID input 1, oWREADY output 1, forming the AXI4-Lite write data channel.
REQ-009 SHALL have ports oBVALID output 1, oBRESP output 2, iBREADY input 1, forming the write response channel.
REQ-010 SHALL have ports oREG_WE output 1, oREG_IDX output 4, oREG_WDATA output 32, oREG_WSTRB output 4, forming the register-file write port.

Function
REQ-011 SHALL define AW handshake as iAWVALID & iAWREADY and W handshake as iWVALID & oWREADY.
REQ-012 SHALL implement states IDLE, WAIT_W (address held), WAIT_A (data held), WRITE, RESP.
REQ-013 IDLE: AW+W handshakes in the same cycle -> WRITE; AW only -> WAIT_W; W only -> WAIT_A; neither -> IDLE.
REQ-014 WAIT_W: W handshake -> WRITE; WAIT_A: AW handshake -> WRITE; otherwise hold.
REQ-015 WRITE SHALL last exactly one cycle, then go to RESP.
REQ-016 RESP: oBVALID=1, held with oBRESP stable until iBREADY=1, then IDLE on the next edge.
REQ-017 SHALL capture iAWADDR on AW handshake and iWDATA/iWSTRB on W handshake into holding registers.
REQ-018 oWREADY SHALL be 1 only in IDLE and WAIT_W.
REQ-019 oBUSY SHALL be combinational: 1 when state != IDLE, or when an AW handshake occurs this cycle. This guarantees that the registered upstream ready drops before a second address is accepted.
REQ-020 oBUSY SHALL be 0 in the cycle in which the B handshake completes, so upstream ready returns in the cycle the block re-enters IDLE.
REQ-021 Register index SHALL be the captured address bits [5:2]; bits [1:0] SHALL be ignored.
REQ-022 Index < NREG: in WRITE, oREG_WE=1 for one cycle, with oREG_IDX, oREG_WDATA and oREG_WSTRB driven from the holding registers; oBRESP=2'b00 (OKAY).
REQ-023 Index >= NREG or captured address bits [31:6] nonzero: oREG_WE SHALL stay 0; oBRESP=2'b10 (SLVERR).
REQ-024 A write with iWSTRB=4'b0000 SHALL still pulse oREG_WE and return OKAY.
REQ-025 Latency SHALL be: last handshake at edge t -> oREG_WE high in cycle t+1 -> oBVALID high from cycle t+2.
REQ-026 oREG_WE SHALL never assert outside WRITE; oREG_IDX/WDATA/WSTRB SHALL be 0 when oREG_WE=0.

Reset
REQ-027 With iRST=1 at an edge, state SHALL become IDLE and all holding registers 0.
REQ-028 Reset values SHALL be: oBVALID=0, oBRESP=0, oREG_WE=0, oWREADY=1, oBUSY=0 (absent an AW handshake).
REQ-029 Reset mid-transaction (any state) SHALL discard the transaction with no oREG_WE pulse and no B response.

Structure
REQ-030 Package axi_wr_pkg SHALL hold the state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the index field bounds (5:2).
REQ-031 SHALL be a single flat module with no sub-module; it connects to the address-channel state machine only via iAWREADY/oBUSY.

Verification
REQ-032 AW 0x0000_0008 and W 0xDEAD_BEEF/4'hF handshaked in the same cycle, iBREADY=1 -> oREG_WE one cycle later with IDX=2 and DATA=0xDEAD_BEEF; oBVALID/OKAY the cycle after.
REQ-033 W before AW (3-cycle gap), address 0x0000_0004 -> WAIT_A entered; oWREADY=0 while waiting; write to IDX=1 after the AW handshake.
REQ-034 Address 0x0000_0020 with NREG=8 -> no oREG_WE, oBRESP=2'b10.
REQ-035 iBREADY held low 5 cycles -> oBVALID and oBRESP stable; oBUSY=1 throughout; upstream ready returns the cycle after the B handshake.
REQ-036 Back-to-back AW presented continuously -> exactly one AW accepted per transaction; no second capture before the B handshake.
REQ-037 iRST=1 asserted in WAIT_W -> next cycle IDLE, oWREADY=1, no oREG_WE pulse, no oBVALID.
